// File: rtl/prog_sequencer.sv
// prog_sequencer: fetches instruction words from a synchronous program ROM
// and feeds them to a processor, one instruction at a time. Each instruction
// is issued with a one-cycle Run pulse. The second word of an mvi is passed
// through on the following cycle. A single-word instruction then waits for
// the processor's Done, bounded by a timeout.
module prog_sequencer #(
    parameter int ADDR_W = 5,
    parameter int TMO    = 4
) (
    input  logic              ClocK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Stop,
    input  logic [9:0]        MemQ,
    input  logic              Done,
    output logic [ADDR_W-1:0] Addr,
    output logic [9:0]        DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [7:0]        InstrCnt
);

    // Opcode field values that change the sequencing.
    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // The wait counter only needs to reach TMO-1 before the timeout fires.
    localparam int WCNT_W = (TMO > 1) ? $clog2(TMO + 1) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_OPERAND,
        S_WAIT,
        S_HALTED,
        S_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [9:0]        ir_reg, ir_next;
    logic [WCNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [7:0]        instr_cnt_reg, instr_cnt_next;
    // A Stop seen while an instruction is in flight is held until the next
    // FETCH, so a short pulse is not lost between instruction boundaries.
    logic              stop_pend_reg, stop_pend_next;

    // State and datapath registers, with synchronous reset taking priority.
    always_ff @(posedge ClocK) begin
        if (Reset) begin
            state_reg     <= S_IDLE;
            pc_reg        <= '0;
            ir_reg        <= '0;
            wait_cnt_reg  <= '0;
            instr_cnt_reg <= '0;
            stop_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            ir_reg        <= ir_next;
            wait_cnt_reg  <= wait_cnt_next;
            instr_cnt_reg <= instr_cnt_next;
            stop_pend_reg <= stop_pend_next;
        end
    end

    // Next-state logic and state-decoded processor outputs.
    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        ir_next        = ir_reg;
        wait_cnt_next  = wait_cnt_reg;
        instr_cnt_next = instr_cnt_reg;
        stop_pend_next = stop_pend_reg;
        DIN            = '0;
        Run            = 1'b0;

        unique case (state_reg)
            // Idle, halted and error all restart the program from address 0.
            S_IDLE, S_HALTED, S_ERROR: begin
                if (Start) begin
                    state_next     = S_FETCH;
                    pc_next        = '0;
                    instr_cnt_next = '0;
                    wait_cnt_next  = '0;
                    // Start wins over a simultaneous Stop; the Stop is
                    // then honoured at the first FETCH.
                    stop_pend_next = Stop;
                end
            end

            // Addr already shows the PC; the ROM word arrives in DECODE.
            S_FETCH: begin
                if (Stop || stop_pend_reg) begin
                    state_next     = S_HALTED;
                    stop_pend_next = 1'b0;
                end else begin
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                ir_next = MemQ;
                if (Stop) begin
                    stop_pend_next = 1'b1;
                end
                if (MemQ[9:6] == OP_HALT) begin
                    // HALT is not issued; PC stays on the HALT word.
                    state_next     = S_HALTED;
                    stop_pend_next = 1'b0;
                end else begin
                    pc_next    = pc_reg + ADDR_W'(1);
                    state_next = S_ISSUE;
                end
            end

            // The only state in which Run is asserted.
            S_ISSUE: begin
                DIN = ir_reg;
                Run = 1'b1;
                if (Stop) begin
                    stop_pend_next = 1'b1;
                end
                if (ir_reg[9:6] == OP_MVI) begin
                    state_next = S_OPERAND;
                end else begin
                    state_next    = S_WAIT;
                    wait_cnt_next = '0;
                end
            end

            // The operand word was addressed during ISSUE and is on MemQ now.
            S_OPERAND: begin
                DIN            = MemQ;
                pc_next        = pc_reg + ADDR_W'(1);
                instr_cnt_next = instr_cnt_reg + 8'd1;
                state_next     = S_FETCH;
                if (Stop) begin
                    stop_pend_next = 1'b1;
                end
            end

            // Wait for the processor, giving up after TMO cycles without Done.
            S_WAIT: begin
                if (Stop) begin
                    stop_pend_next = 1'b1;
                end
                if (Done) begin
                    instr_cnt_next = instr_cnt_reg + 8'd1;
                    state_next     = S_FETCH;
                end else if (wait_cnt_reg == WCNT_LAST) begin
                    state_next = S_ERROR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded directly from registered state.
    always_comb begin
        Addr     = pc_reg;
        InstrCnt = instr_cnt_reg;
        Halted   = (state_reg == S_HALTED);
        Error    = (state_reg == S_ERROR);
        Busy     = !((state_reg == S_IDLE) || (state_reg == S_HALTED) ||
                     (state_reg == S_ERROR));
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer: a synchronous ROM model and a
// simple processor model that raises Done a programmable number of WAIT
// cycles after each Run pulse.
module tb_prog_sequencer;

    logic       clk = 1'b0;
    logic       srst;
    logic       start;
    logic       stop;
    logic       done = 1'b0;
    logic [9:0] mem_q = '0;
    logic [4:0] addr;
    logic [9:0] din;
    logic       run;
    logic       busy;
    logic       halted;
    logic       error;
    logic [7:0] instr_cnt;

    logic [9:0] rom [0:31];
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_at  = 0;   // 0: processor never answers
    int         proc_cnt = 200;
    int         run_cnt;
    logic [9:0] run_din;
    int         cyc;
    logic       found;

    always #5 clk = ~clk;

    prog_sequencer #(.ADDR_W(5), .TMO(4)) dut (
        .ClocK    (clk),
        .Reset    (srst),
        .Start    (start),
        .Stop     (stop),
        .MemQ     (mem_q),
        .Done     (done),
        .Addr     (addr),
        .DIN      (din),
        .Run      (run),
        .Busy     (busy),
        .Halted   (halted),
        .Error    (error),
        .InstrCnt (instr_cnt)
    );

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) mem_q <= rom[addr];

    // Processor model: Done high in the done_at-th cycle after the Run cycle.
    always @(negedge clk) begin
        if (run) proc_cnt = 0;
        else if (proc_cnt < 200) proc_cnt = proc_cnt + 1;
        done = (done_at != 0) && !run && (proc_cnt == done_at);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse Start and run until Halted or Error, counting cycles from the first FETCH.
    task automatic run_prog(input string tag, input int max);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        run_cnt = 0;
        run_din = '0;
        while (!(halted || error) && cyc < max) begin
            if (run) begin
                run_cnt++;
                run_din = din;
            end
            step();
            cyc++;
        end
        check({tag, "_ended"}, halted | error, 1);
        $display("%s: cycles=%0d runs=%0d din=0x%0h cnt=%0d addr=%0d", tag, cyc, run_cnt, run_din, instr_cnt, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        srst  = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 10'h3C0;

        // Reset state
        repeat (3) step();
        check("rst_addr", addr, 0);
        check("rst_din", din, 0);
        check("rst_run", run, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_cnt", instr_cnt, 0);
        srst = 1'b0;
        step();
        check("idle_busy", busy, 0);

        // mv then HALT, Done on the first WAIT cycle
        rom[0] = 10'h001; rom[1] = 10'h3C0; done_at = 1;
        run_prog("a", 50);
        check("a_runs", run_cnt, 1);
        check("a_din", run_din, 10'h001);
        check("a_halted", halted, 1);
        check("a_busy", busy, 0);
        check("a_cnt", instr_cnt, 1);
        check("a_addr", addr, 1);
        check("a_cycles", cyc, 7);

        // mvi then HALT, restarting from HALTED
        rom[0] = 10'h050; rom[1] = 10'h155; rom[2] = 10'h3C0; done_at = 0;
        start = 1'b1; step(); start = 1'b0;
        check("b_restart_cnt", instr_cnt, 0);
        check("b_restart_halted", halted, 0);
        check("b_restart_addr", addr, 0);
        step(); step();
        check("b_issue_run", run, 1);
        check("b_issue_din", din, 10'h050);
        step();
        check("b_op_run", run, 0);
        check("b_op_din", din, 10'h155);
        step(); step(); step();
        check("b_halted", halted, 1);
        check("b_cnt", instr_cnt, 1);
        check("b_addr", addr, 2);
        $display("b: mvi issue/operand sequence done cnt=%0d addr=%0d", instr_cnt, addr);

        // add with Done on the third WAIT cycle: 6 cycles FETCH to FETCH
        rom[0] = 10'h080; rom[1] = 10'h3C0; done_at = 3;
        run_prog("c", 50);
        check("c_cycles", cyc, 9);
        check("c_cnt", instr_cnt, 1);
        check("c_runs", run_cnt, 1);

        // Opcode 1100 with no Done: timeout to ERROR, then restart
        rom[0] = 10'h300; done_at = 0;
        run_prog("d", 50);
        check("d_cycles", cyc, 8);
        check("d_error", error, 1);
        check("d_busy", busy, 0);
        check("d_halted", halted, 0);
        rom[0] = 10'h3C0;
        start = 1'b1; step(); start = 1'b0;
        check("d_restart_error", error, 0);
        check("d_restart_addr", addr, 0);
        check("d_restart_busy", busy, 1);
        step(); step();
        check("d_restart_halted", halted, 1);
        check("d_restart_cnt", instr_cnt, 0);

        // 32-word program, mvi at address 31 takes its operand from address 0
        for (int i = 0; i < 32; i++) rom[i] = 10'h001;
        rom[0] = 10'h00A; rom[31] = 10'h050; done_at = 1;
        start = 1'b1; step(); start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (run && din == 10'h050) found = 1'b1;
            else step();
        end
        check("e_found", found, 1);
        check("e_wrap_addr", addr, 0);
        check("e_wrap_cnt", instr_cnt, 31);
        step();
        check("e_op_din", din, 10'h00A);
        check("e_op_run", run, 0);
        step();
        check("e_fetch_addr", addr, 1);
        check("e_fetch_cnt", instr_cnt, 32);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("e_halted", halted, 1);
        check("e_halt_addr", addr, 1);
        $display("e: wrap program halted cnt=%0d addr=%0d", instr_cnt, addr);

        // Reset asserted during WAIT
        rom[0] = 10'h001; rom[1] = 10'h080; done_at = 1;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step(); step();
        done_at = 0;
        step(); step(); step(); step();
        check("f_busy", busy, 1);
        check("f_cnt", instr_cnt, 1);
        check("f_addr", addr, 2);
        srst = 1'b1;
        step();
        check("f_rst_addr", addr, 0);
        check("f_rst_din", din, 0);
        check("f_rst_run", run, 0);
        check("f_rst_busy", busy, 0);
        check("f_rst_halted", halted, 0);
        check("f_rst_error", error, 0);
        check("f_rst_cnt", instr_cnt, 0);
        srst = 1'b0;
        step();
        $display("f: reset during WAIT returned to idle");

        // Start and Stop together in IDLE: first FETCH goes to HALTED
        rom[0] = 10'h001;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0;
        check("h_busy", busy, 1);
        check("h_addr", addr, 0);
        step();
        stop = 1'b0;
        check("h_halted", halted, 1);
        check("h_cnt", instr_cnt, 0);
        check("h_addr2", addr, 0);
        $display("h: start+stop halted at first fetch");

        // Stop (and an ignored Start) raised during WAIT
        rom[0] = 10'h080; rom[1] = 10'h001; done_at = 2;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        stop = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("g_wait_busy", busy, 1);
        step();
        check("g_fetch_cnt", instr_cnt, 1);
        check("g_fetch_busy", busy, 1);
        step();
        stop = 1'b0;
        check("g_halted", halted, 1);
        check("g_addr", addr, 1);
        check("g_cnt", instr_cnt, 1);
        $display("g: stop during WAIT halted cnt=%0d addr=%0d", instr_cnt, addr);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
